// File: rtl/path_pkg.sv
// Shared constants, node type and tracer state encoding for the path tracer.
package path_pkg;

    localparam int N_NODES  = 13;
    localparam int NODE_W   = 4;
    localparam int DIST_W   = 14;
    localparam int INF_DIST = 99;

    typedef logic [NODE_W-1:0] node_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WALK  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FIN   = 3'd4,
        ST_ERR   = 3'd5
    } tracer_state_e;

endpackage

// File: rtl/path_stack.sv
// LIFO holding the route while it is walked backward; popped forward on emit.
// A push while full overwrites the top entry so the depth never wraps.
module path_stack
    import path_pkg::*;
#(
    parameter int DEPTH = N_NODES,
    parameter int WIDTH = NODE_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNT_W-1:0] depth_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] depth_q;

    assign full_o  = (depth_q == CNT_W'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;
    assign top_o   = empty_o ? '0 : mem_q[depth_q - 1'b1];

    // Depth counter: clear wins over push, push wins over pop, saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (clear_i) begin
            depth_q <= '0;
        end else if (push_i) begin
            if (!full_o) begin
                depth_q <= depth_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Storage: a push when full replaces the topmost entry instead of growing.
    always_ff @(posedge clk) begin
        if (!reset && !clear_i && push_i) begin
            if (full_o) begin
                mem_q[DEPTH-1] <= data_i;
            end else begin
                mem_q[depth_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor table backward from end_node to start_node, then
// streams the route start-to-end over a valid/ready handshake.
// Optional macro PATH_TRACER_LOOP_CHECK_EN: abort the walk when the stack
// fills without reaching start_node (protects against cyclic tables).
module path_tracer #(
    parameter int N_NODES  = path_pkg::N_NODES,
    parameter int NODE_W   = path_pkg::NODE_W,
    parameter int DIST_W   = path_pkg::DIST_W,
    parameter int INF_DIST = path_pkg::INF_DIST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NODE_W-1:0] start_node,
    input  logic [NODE_W-1:0] end_node,
    input  logic [DIST_W-1:0] dist_end,
    output logic [NODE_W-1:0] pred_addr,
    input  logic [NODE_W-1:0] pred_data,
    output logic              busy,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [NODE_W-1:0] step_node,
    output logic              step_last,
    output logic [NODE_W:0]   path_len,
    output logic              done,
    output logic              error
);

    import path_pkg::*;

    localparam int CNT_W = $clog2(N_NODES + 1);
    localparam int IDX_W = NODE_W + 1;

    tracer_state_e     state_q, state_d;
    logic [NODE_W-1:0] startNode_q, startNode_d;
    logic [NODE_W-1:0] endNode_q, endNode_d;
    logic [DIST_W-1:0] distEnd_q, distEnd_d;
    logic [NODE_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]  walkDepth_q, walkDepth_d;
    logic [NODE_W:0]   pathLen_q, pathLen_d;

    logic              stackClear, stackPush, stackPop;
    logic [NODE_W-1:0] stackData, stackTop;
    logic [CNT_W-1:0]  stackDepth;
    logic              stackFull, stackEmpty;
    logic              stepValid, stepLast, requestBad;

    path_stack #(
        .DEPTH (N_NODES),
        .WIDTH (NODE_W)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .clear_i (stackClear),
        .push_i  (stackPush),
        .pop_i   (stackPop),
        .data_i  (stackData),
        .top_o   (stackTop),
        .depth_o (stackDepth),
        .full_o  (stackFull),
        .empty_o (stackEmpty)
    );

`ifdef PATH_TRACER_LOOP_CHECK_EN
    // stackFull drives the loop abort in WALK.
`else
    logic unusedFull;
    assign unusedFull = stackFull;
`endif

    assign requestBad = (distEnd_q >= DIST_W'(INF_DIST))
                     || ({1'b0, startNode_q} >= IDX_W'(N_NODES))
                     || ({1'b0, endNode_q} >= IDX_W'(N_NODES));

    assign stepValid  = (state_q == ST_EMIT) && !stackEmpty;
    assign stepLast   = stepValid && (stackDepth == CNT_W'(1));
    assign step_valid = stepValid;
    assign step_last  = stepLast;
    assign step_node  = stepValid ? stackTop : '0;
    assign pred_addr  = (state_q == ST_WALK) ? cur_q : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign error      = (state_q == ST_ERR);
    assign path_len   = pathLen_q;

    // Next-state logic: latch request, validate, walk predecessors, emit route.
    always_comb begin
        state_d     = state_q;
        startNode_d = startNode_q;
        endNode_d   = endNode_q;
        distEnd_d   = distEnd_q;
        cur_d       = cur_q;
        walkDepth_d = walkDepth_q;
        pathLen_d   = pathLen_q;
        stackClear  = 1'b0;
        stackPush   = 1'b0;
        stackPop    = 1'b0;
        stackData   = pred_data;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    startNode_d = start_node;
                    endNode_d   = end_node;
                    distEnd_d   = dist_end;
                    stackClear  = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (requestBad) begin
                    state_d = ST_ERR;
                end else begin
                    stackPush = 1'b1;
                    stackData = endNode_q;
                    cur_d     = endNode_q;
                    state_d   = ST_WALK;
                end
            end
            ST_WALK: begin
                if (cur_q == startNode_q) begin
                    walkDepth_d = stackDepth;
                    state_d     = ST_EMIT;
                end
`ifdef PATH_TRACER_LOOP_CHECK_EN
                else if (stackFull) begin
                    state_d = ST_ERR;
                end
`endif
                else begin
                    stackPush = 1'b1;
                    cur_d     = pred_data;
                end
            end
            ST_EMIT: begin
                if (stepValid && step_ready) begin
                    stackPop = 1'b1;
                    if (stepLast) begin
                        pathLen_d = IDX_W'(walkDepth_q);
                        state_d   = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            startNode_q <= '0;
            endNode_q   <= '0;
            distEnd_q   <= '0;
            cur_q       <= '0;
            walkDepth_q <= '0;
            pathLen_q   <= '0;
        end else begin
            state_q     <= state_d;
            startNode_q <= startNode_d;
            endNode_q   <= endNode_d;
            distEnd_q   <= distEnd_d;
            cur_q       <= cur_d;
            walkDepth_q <= walkDepth_d;
            pathLen_q   <= pathLen_d;
        end
    end

endmodule

// File: tb/tb_path_tracer.sv
// Self-checking bench for path_tracer: directed scenarios plus randomized
// acyclic routes compared against a route model built from the table.
module tb_path_tracer;

    localparam int N   = 13;
    localparam int INF = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  start_node, end_node;
    logic [13:0] dist_end;
    logic [3:0]  pred_addr, pred_data;
    logic        busy, step_valid, step_ready, step_last, done, error;
    logic [3:0]  step_node;
    logic [4:0]  path_len;

    logic [3:0]  predTable [16];
    int          testsRun  = 0;
    int          failCount = 0;
    int          lastLen   = 0;
    int          expRoute[$];

    always #5 clk = ~clk;

    assign pred_data = predTable[pred_addr];

    path_tracer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_node (start_node),
        .end_node   (end_node),
        .dist_end   (dist_end),
        .pred_addr  (pred_addr),
        .pred_data  (pred_data),
        .busy       (busy),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_node  (step_node),
        .step_last  (step_last),
        .path_len   (path_len),
        .done       (done),
        .error      (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    // Reference route: follow predecessors from e back to s, list forward.
    task automatic buildRoute(input int s, input int e);
        int cur;
        int guard;
        expRoute.delete();
        cur = e;
        guard = 0;
        expRoute.push_front(cur);
        while (cur != s && guard < 32) begin
            cur = int'(predTable[cur]);
            expRoute.push_front(cur);
            guard++;
        end
    endtask

    // One request: mode 0 ready high, 1 random ready, 2 stall 3 cycles on stallNode.
    task automatic applyStimulus(input int s, input int e, input int d, input int mode,
                                 input int stallNode, input bit inject);
        bit expErr;
        int expLen, idx, n, firstValid, doneAt, errAt, stallLeft;
        bit injected, r;
        expErr = (d >= INF) || (s >= N) || (e >= N);
        expLen = 0;
        if (!expErr) begin
            buildRoute(s, e);
            expLen = expRoute.size();
        end
        idx = 0; firstValid = -1; doneAt = -1; errAt = -1; stallLeft = 3; injected = 0;
        start = 1'b1;
        start_node = 4'(s);
        end_node = 4'(e);
        dist_end = 14'(d);
        step_ready = 1'b0;
        tick();
        start = 1'b0;
        n = 1;
        checkOutput("busyInCheck", 32'(busy), 1);
        while (n < 200 && doneAt < 0 && errAt < 0) begin
            if (step_valid) begin
                if (firstValid < 0) firstValid = n;
                if (idx < expLen) begin
                    checkOutput("stepNode", 32'(step_node), expRoute[idx]);
                    checkOutput("stepLast", 32'(step_last), 32'(idx == expLen - 1));
                end else begin
                    checkOutput("stepCount", idx, expLen - 1);
                end
            end
            if (done) doneAt = n;
            if (error) errAt = n;
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else if (step_valid && int'(step_node) == stallNode && stallLeft > 0) begin
                r = 1'b0;
                stallLeft--;
            end else begin
                r = 1'b1;
            end
            step_ready = r;
            if (step_valid && r) idx++;
            if (inject && step_valid && !injected) begin
                start = 1'b1;
                start_node = 4'd0;
                end_node = 4'd5;
                dist_end = 14'd3;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (doneAt < 0 && errAt < 0) begin
                tick();
                n++;
            end
        end
        step_ready = 1'b0;
        start = 1'b0;
        if (expErr) begin
            checkOutput("errorCycle", errAt, 2);
            checkOutput("noDoneOnErr", doneAt, -1);
            checkOutput("noValidOnErr", firstValid, -1);
            checkOutput("pathLenKept", 32'(path_len), lastLen);
        end else begin
            if (mode == 0) checkOutput("doneCycle", doneAt, 2 * expLen + 2);
            else checkOutput("doneSeen", 32'(doneAt > 0), 1);
            checkOutput("noErr", errAt, -1);
            checkOutput("firstValid", firstValid, expLen + 2);
            checkOutput("nodesEmitted", idx, expLen);
            checkOutput("pathLen", 32'(path_len), expLen);
            lastLen = expLen;
        end
        tick();
        checkOutput("idleAfter", 32'(busy), 0);
    endtask

    initial begin
        int perm[13];
        int L, s, e, d, tmp, j, errAt, busyLow;
        reset = 1'b1;
        start = 1'b0;
        start_node = '0;
        end_node = '0;
        dist_end = '0;
        step_ready = 1'b0;
        for (int i = 0; i < 16; i++) predTable[i] = 4'd0;
        tick();
        tick();
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstValid", 32'(step_valid), 0);
        checkOutput("rstLast", 32'(step_last), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstError", 32'(error), 0);
        checkOutput("rstNode", 32'(step_node), 0);
        checkOutput("rstAddr", 32'(pred_addr), 0);
        checkOutput("rstLen", 32'(path_len), 0);
        reset = 1'b0;
        tick();

        predTable[2] = 4'd8;
        predTable[8] = 4'd9;
        predTable[9] = 4'd10;
        applyStimulus(10, 2, 6, 0, -1, 0);
        applyStimulus(10, 10, 0, 0, -1, 0);
        applyStimulus(10, 2, 99, 0, -1, 0);
        applyStimulus(10, 2, 6, 2, 9, 0);
        applyStimulus(10, 2, 6, 0, -1, 1);
        applyStimulus(10, 14, 6, 0, -1, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) predTable[i] = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            L = $urandom_range(1, 8);
            for (int i = 1; i < L; i++) predTable[perm[i]] = 4'(perm[i-1]);
            s = perm[0];
            e = perm[L-1];
            d = ($urandom_range(0, 4) == 0) ? $urandom_range(99, 300) : $urandom_range(0, 98);
            applyStimulus(s, e, d, $urandom_range(0, 1), -1, 0);
        end

        predTable[3] = 4'd5;
        predTable[5] = 4'd3;
        start = 1'b1;
        start_node = 4'd0;
        end_node = 4'd3;
        dist_end = 14'd7;
        tick();
        start = 1'b0;
        errAt = -1;
        busyLow = 0;
        for (int n = 1; n < 40; n++) begin
            if (error && errAt < 0) errAt = n;
            if (!busy) busyLow++;
            tick();
        end
`ifdef PATH_TRACER_LOOP_CHECK_EN
        checkOutput("loopErrCycle", errAt, 15);
`else
        checkOutput("loopNoErr", errAt, -1);
        checkOutput("loopBusyHeld", busyLow, 0);
`endif
        reset = 1'b1;
        tick();
        checkOutput("loopRstBusy", 32'(busy), 0);
        checkOutput("loopRstValid", 32'(step_valid), 0);
        checkOutput("loopRstAddr", 32'(pred_addr), 0);
        checkOutput("loopRstLen", 32'(path_len), 0);
        reset = 1'b0;
        lastLen = 0;
        tick();

        predTable[2] = 4'd8;
        predTable[8] = 4'd9;
        predTable[9] = 4'd10;
        start = 1'b1;
        start_node = 4'd10;
        end_node = 4'd2;
        dist_end = 14'd6;
        step_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        checkOutput("midValidBefore", 32'(step_valid), 1);
        reset = 1'b1;
        tick();
        checkOutput("midRstValid", 32'(step_valid), 0);
        checkOutput("midRstDone", 32'(done), 0);
        checkOutput("midRstError", 32'(error), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        reset = 1'b0;
        step_ready = 1'b0;
        tick();
        checkOutput("midNoDone", 32'(done), 0);
        checkOutput("midNoError", 32'(error), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/path_tracer.md
# path_tracer

Path-reconstruction reader for the shortest-path engine. After the engine finishes its relaxation passes, this block walks the predecessor table backward from a requested end node to the start node. It then streams the resulting route forward, start to end, one node per valid/ready handshake, to the motion/route sequencer. It is the consumer of the engine's `previous_node`/`distance_from_start` arrays.

## Interface
Parameters:
- `N_NODES`, default 13: graph node count and stack depth.
- `NODE_W`, default 4: node index width.
- `DIST_W`, default 14: distance word width.
- `INF_DIST`, default 99: "unreached" distance value.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle request pulse; ignored while `busy`.
- `start_node`  in  NODE_W: route origin; sampled with `start`.
- `end_node`  in  NODE_W: route destination; sampled with `start`.
- `dist_end`  in  DIST_W: engine distance of `end_node`; sampled with `start`.
- `pred_addr`  out  NODE_W: predecessor table read address.
- `pred_data`  in  NODE_W: predecessor of `pred_addr`; combinational, same cycle.
- `busy`  out  1: high in every state except IDLE.
- `step_valid`  out  1: `step_node` is valid.
- `step_ready`  in  1: downstream accepts the current node.
- `step_node`  out  NODE_W: current route node.
- `step_last`  out  1: current node is `end_node`.
- `path_len`  out  NODE_W+1: node count of the last successful route.
- `done`  out  1: one-cycle pulse when the route has been fully streamed.
- `error`  out  1: one-cycle pulse when a request is aborted.

## Operation
States: IDLE, CHECK, WALK, EMIT, FIN, ERR.

- **IDLE**
  - On `start`: latch the inputs, clear the stack, go to CHECK.
- **CHECK**
  - If `dist_end >= INF_DIST`, or either node index `>= N_NODES`: go to ERR.
  - Otherwise: push `end_node`, set `cur = end_node`, go to WALK.
- **WALK**, one cycle per step:
  - Drive `pred_addr = cur`.
  - If `cur == start_node`: go to EMIT.
  - Otherwise, with the loop check enabled and depth == N_NODES: go to ERR.
  - Otherwise: push `pred_data`, set `cur = pred_data`.
- **EMIT**
  - `step_valid` = 1 and `step_node` = stack top.
  - `step_last` = 1 when depth == 1.
  - Each `step_valid && step_ready` pops one entry.
  - The pop with `step_last` set goes to FIN.
- **FIN**: `done` = 1 for one cycle; `path_len` updated to the walked depth; return to IDLE.
- **ERR**: `error` = 1 for one cycle; `path_len` unchanged; return to IDLE.

Boundary rules:
- `start_node == end_node`: one node emitted, `path_len` = 1.
- `start` while busy: ignored; latched values unchanged.
- Stack depth saturates at N_NODES; no wrap-around.

## Timing
- Reset values: state IDLE, stack depth 0, `busy`/`step_valid`/`step_last`/`done`/`error` all 0, `step_node`/`pred_addr`/`path_len` all 0.
- Route of L nodes, `start` sampled at edge T:
  - CHECK occupies cycle T+1.
  - WALK occupies cycles T+2 .. T+L+1.
  - `step_valid` is first high in cycle T+L+2.
- With `step_ready` held high: one node per cycle, `done` in cycle T+2L+2.
- While `step_valid && !step_ready`: `step_node` and `step_last` hold stable.
- `reset` mid-operation: returns to IDLE at that edge and drops `step_valid`; no `done` or `error` pulse.

## Configuration
- `PATH_TRACER_LOOP_CHECK_EN` defined:
  - WALK aborts to ERR when depth reaches N_NODES without reaching `start_node`.
- `PATH_TRACER_LOOP_CHECK_EN` undefined:
  - There is no depth check; pushes beyond N_NODES overwrite the top entry.
  - A cyclic predecessor table keeps the block in WALK until `reset`.
  - Producer guarantees an acyclic table.

## Structure
- Package `path_pkg`:
  - N_NODES, NODE_W, DIST_W, INF_DIST constants.
  - `node_t` typedef.
  - Tracer state enum.
- Sub-module `path_stack`:
  - N_NODES-deep LIFO with push, pop, clear.
  - Outputs: top, depth, full, empty.

## Test plan
- Engine table for start 10 (pred[2]=8, pred[8]=9, pred[9]=10), `end_node`=2, `dist_end`=6, ready high -> emits 10, 9, 8, 2; `step_last` on node 2; `path_len`=4; `done` in cycle T+10.
- `start_node` = `end_node` = 10, `dist_end`=0 -> single node 10 with `step_last`=1, `path_len`=1, `done` at T+4.
- `dist_end`=99 -> `error` pulse at T+2, `step_valid` never asserted, `path_len` keeps its previous value.
- Same route as the first scenario, `step_ready` low for 3 cycles while node 9 is presented -> node 9 held stable, no loss or duplicate, sequence 10, 9, 8, 2.
- pred[3]=5, pred[5]=3, start 0, end 3, `dist_end`=7:
  - Macro defined -> `error` after 13 pushes.
  - Macro undefined -> `busy` stays high; `reset` returns to IDLE with all outputs 0.
- `start` pulsed during EMIT with different nodes -> ignored; the current route completes unchanged.
